// File: rtl/button_debouncer_if.sv
// button_debouncer_if: control and status signals of the button debouncer.
// The master side drives enable and raw pads; the slave returns conditioned levels and pulses.
interface button_debouncer_if #(
    parameter int N = 4
);
    logic         i_en;
    logic [N-1:0] i_btn_in;
    logic [N-1:0] o_btn_level;
    logic [N-1:0] o_btn_rise;
    logic [N-1:0] o_btn_fall;
    logic         o_tick;
    modport master (output i_en, i_btn_in, input o_btn_level, o_btn_rise, o_btn_fall, o_tick);
    modport slave  (input i_en, i_btn_in, output o_btn_level, o_btn_rise, o_btn_fall, o_tick);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises N raw pads, debounces them on a prescaled sample tick,
// and produces clean levels plus single-cycle rise/fall strobes.
module button_debouncer #(
    parameter int N          = 4,
    parameter int PRESCALE_W = 18,
    parameter int STABLE_CNT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    button_debouncer_if.slave        bus
);
    localparam int CW = $clog2(STABLE_CNT + 1);
    logic [N-1:0]          r_s1, r_s2, r_lvl, r_rise, r_fall;
    logic [PRESCALE_W-1:0] r_pre;
    logic [CW-1:0]         r_cnt [N];
    logic                  w_tick;
    assign w_tick          = bus.i_en & (&r_pre);
    assign bus.o_tick      = w_tick;
    assign bus.o_btn_level = r_lvl;
    assign bus.o_btn_rise  = r_rise;
    assign bus.o_btn_fall  = r_fall;
    // The counter only advances on ticks where the synchronised input disagrees with the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_pre  <= '0;
            r_lvl  <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            r_s1   <= bus.i_btn_in;
            r_s2   <= r_s1;
            r_pre  <= bus.i_en ? r_pre + 1'b1 : r_pre;
            r_rise <= '0;
            r_fall <= '0;
            if (w_tick) begin
                for (int i = 0; i < N; i++) begin
                    if (r_s2[i] == r_lvl[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == CW'(STABLE_CNT - 1)) begin
                        r_cnt[i]  <= '0;
                        r_lvl[i]  <= r_s2[i];
                        r_rise[i] <= r_s2[i];
                        r_fall[i] <= ~r_s2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed scenarios for button_debouncer with N=4, PRESCALE_W=4, STABLE_CNT=3.
// Inputs change only just after a consumed tick, so every expected latency is counted in ticks.
module tb_button_debouncer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    button_debouncer_if #(.N(4)) bus ();
    button_debouncer #(.N(4), .PRESCALE_W(4), .STABLE_CNT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    // Waits (bounded) for tick at a falling edge, lets the next rising edge consume it,
    // and returns to the following falling edge so the results of that tick are visible.
    task automatic tick_edge(output int waited);
        waited = 0;
        while (bus.o_tick !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (bus.o_tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", bus.o_tick, waited);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.i_en = 1'b1;
        bus.i_btn_in = 4'b0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_btn_level, bus.o_btn_rise, bus.o_btn_fall, bus.o_tick} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: lvl=%b rise=%b fall=%b tick=%b, required all 0",
                     bus.o_btn_level, bus.o_btn_rise, bus.o_btn_fall, bus.o_tick);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 48; e++) begin
            @(negedge clk);
            checks++;
            if (bus.o_tick !== (e % 16 == 15)) begin
                failures++;
                $display("FAIL tick_cadence: cycle %0d tick=%b, required %b", e, bus.o_tick, e % 16 == 15);
            end
        end
        checks++;
        if (bus.o_btn_level !== 4'b0000) begin
            failures++;
            $display("FAIL idle_level: lvl=%b, required 0000", bus.o_btn_level);
        end
    endtask

    task automatic test_clean_press();
        int w;
        bus.i_btn_in = 4'b0001;
        tick_edge(w);
        checks++;
        if (w !== 15) begin
            failures++;
            $display("FAIL press_tick_phase: waited=%0d, required 15", w);
        end
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0000) begin
            failures++;
            $display("FAIL press_early: lvl=%b after 2 ticks, required 0000", bus.o_btn_level);
        end
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0001 || bus.o_btn_rise !== 4'b0001 || bus.o_btn_fall !== 4'b0000) begin
            failures++;
            $display("FAIL press_accept: lvl=%b rise=%b fall=%b, required 0001 0001 0000",
                     bus.o_btn_level, bus.o_btn_rise, bus.o_btn_fall);
        end
        @(negedge clk);
        checks++;
        if (bus.o_btn_level !== 4'b0001 || bus.o_btn_rise !== 4'b0000) begin
            failures++;
            $display("FAIL press_pulse_width: lvl=%b rise=%b, required 0001 0000", bus.o_btn_level, bus.o_btn_rise);
        end
    endtask

    task automatic test_bounce();
        int w;
        bus.i_btn_in = 4'b0011;
        tick_edge(w);
        tick_edge(w);
        bus.i_btn_in = 4'b0001;
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0001) begin
            failures++;
            $display("FAIL bounce_low_tick: lvl=%b, required 0001", bus.o_btn_level);
        end
        bus.i_btn_in = 4'b0011;
        tick_edge(w);
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0001 || bus.o_btn_rise !== 4'b0000) begin
            failures++;
            $display("FAIL bounce_count_reset: lvl=%b rise=%b after 2 high ticks, required 0001 0000",
                     bus.o_btn_level, bus.o_btn_rise);
        end
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0011 || bus.o_btn_rise !== 4'b0010) begin
            failures++;
            $display("FAIL bounce_accept: lvl=%b rise=%b, required 0011 0010", bus.o_btn_level, bus.o_btn_rise);
        end
    endtask

    task automatic test_glitch();
        int w;
        repeat (5) @(negedge clk);
        bus.i_btn_in = 4'b1011;
        repeat (3) @(negedge clk);
        bus.i_btn_in = 4'b0011;
        for (int t = 0; t < 3; t++) tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0011 || bus.o_btn_rise !== 4'b0000) begin
            failures++;
            $display("FAIL glitch_ignored: lvl=%b rise=%b, required 0011 0000", bus.o_btn_level, bus.o_btn_rise);
        end
    endtask

    task automatic test_enable_freeze();
        int w;
        bus.i_btn_in = 4'b0111;
        tick_edge(w);
        tick_edge(w);
        bus.i_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_tick !== 1'b0 || bus.o_btn_level !== 4'b0011) begin
                failures++;
                $display("FAIL freeze: cycle %0d tick=%b lvl=%b, required 0 0011", c, bus.o_tick, bus.o_btn_level);
            end
        end
        bus.i_en = 1'b1;
        tick_edge(w);
        checks++;
        if (w !== 15) begin
            failures++;
            $display("FAIL freeze_phase: waited=%0d, required 15", w);
        end
        checks++;
        if (bus.o_btn_level !== 4'b0111 || bus.o_btn_rise !== 4'b0100) begin
            failures++;
            $display("FAIL freeze_resume: lvl=%b rise=%b, required 0111 0100", bus.o_btn_level, bus.o_btn_rise);
        end
    endtask

    task automatic test_simultaneous();
        int w;
        bus.i_btn_in = 4'b1011;
        tick_edge(w);
        tick_edge(w);
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b1011 || bus.o_btn_rise !== 4'b1000 || bus.o_btn_fall !== 4'b0100) begin
            failures++;
            $display("FAIL simultaneous: lvl=%b rise=%b fall=%b, required 1011 1000 0100",
                     bus.o_btn_level, bus.o_btn_rise, bus.o_btn_fall);
        end
        @(negedge clk);
        checks++;
        if (bus.o_btn_rise !== 4'b0000 || bus.o_btn_fall !== 4'b0000) begin
            failures++;
            $display("FAIL simultaneous_width: rise=%b fall=%b, required 0000 0000", bus.o_btn_rise, bus.o_btn_fall);
        end
    endtask

    task automatic test_async_reset();
        int w;
        bus.i_btn_in = 4'b0010;
        for (int t = 0; t < 3; t++) tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0010 || bus.o_btn_fall !== 4'b1001) begin
            failures++;
            $display("FAIL release_multi: lvl=%b fall=%b, required 0010 1001", bus.o_btn_level, bus.o_btn_fall);
        end
        bus.i_btn_in = 4'b0011;
        tick_edge(w);
        tick_edge(w);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_btn_level !== 4'b0000 || bus.o_tick !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: lvl=%b tick=%b, required 0000 0", bus.o_btn_level, bus.o_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick_edge(w);
        checks++;
        if (w !== 15) begin
            failures++;
            $display("FAIL reset_tick_phase: waited=%0d, required 15", w);
        end
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0000) begin
            failures++;
            $display("FAIL reset_cnt_cleared: lvl=%b after 2 ticks, required 0000", bus.o_btn_level);
        end
        tick_edge(w);
        checks++;
        if (bus.o_btn_level !== 4'b0011 || bus.o_btn_rise !== 4'b0011) begin
            failures++;
            $display("FAIL reset_reaccept: lvl=%b rise=%b, required 0011 0011", bus.o_btn_level, bus.o_btn_rise);
        end
    endtask

    initial begin
        bus.i_en = 1'b1;
        bus.i_btn_in = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_enable_freeze();
        test_simultaneous();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Multi-channel input conditioner for the board's push-buttons and slide switches. It synchronises raw pad inputs to `clk`, debounces them against a prescaled sample tick, and delivers clean levels plus single-cycle rise/fall pulses. These pulses drive the `en`/`reset`/init-style control inputs of the counter and LED blocks. It is the input-side counterpart of the prescaled LED counter path: physical pins in, control strobes out.

## Interface
- `N`, 4: number of independent input channels (1..16)
- `PRESCALE_W`, 18: prescaler width; one sample tick every 2^PRESCALE_W enabled cycles (≈5.2 ms at 50 MHz)
- `STABLE_CNT`, 4: consecutive disagreeing ticks required to accept a new level (≥1)

- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `en`  in  1  prescaler enable; low freezes sampling
- `btn_in`  in  N  raw asynchronous pad inputs
- `btn_level`  out  N  debounced level
- `btn_rise`  out  N  one-cycle pulse on accepted 0→1
- `btn_fall`  out  N  one-cycle pulse on accepted 1→0
- `tick`  out  1  sample strobe, high one cycle per prescaler wrap

## Operation
- Synchroniser: each `btn_in` bit passes through two flops (`s1`, `s2`). Debounce logic sees only `s2`. Synchronisers run regardless of `en`.
- Prescaler: a PRESCALE_W-bit up-counter that increments when `en`=1 and holds when `en`=0. It wraps from 2^W−1 to 0.
- `tick` = `en` AND (prescaler == 2^W−1). Combinational decode, with no tick while `en`=0.
- Per channel: stable register `lvl` (drives `btn_level`) and disagreement counter `cnt`, width clog2(STABLE_CNT+1).
- Action on a `tick` edge, per channel:
  - `s2` == `lvl`: `cnt` ← 0.
  - `s2` != `lvl` and `cnt` == STABLE_CNT−1: `lvl` ← `s2`, `cnt` ← 0. Pulse `btn_rise` if new `lvl`=1, `btn_fall` if new `lvl`=0.
  - `s2` != `lvl` otherwise: `cnt` ← `cnt`+1.
- Between ticks, `lvl` and `cnt` hold, and any input glitch not present at a tick is ignored.
- Channels are fully independent. Any combination of channels may update on the same tick.
- Reset values:
  - prescaler, `s1`, `s2`, `lvl`, `cnt`: 0.
  - `btn_level`, `btn_rise`, `btn_fall`: 0.
  - `tick`: 0, because prescaler = 0.
- An input held high through reset release is accepted as a press after STABLE_CNT ticks, and `btn_rise` fires at that point.

## Timing
- Synchroniser latency: 2 clock edges from a `btn_in` change to `s2`.
- Accept latency: `lvl` changes on the edge of the STABLE_CNT-th consecutive tick at which `s2` != `lvl`.
  - Worst case ≈ 2 + STABLE_CNT·2^W cycles.
  - Best case ≈ 2 + (STABLE_CNT−1)·2^W + 1 cycles.
- `btn_rise`/`btn_fall` are registered:
  - Asserted in the cycle that `btn_level` first shows the new value.
  - Exactly one cycle wide.
  - Never both high on one channel.
- First `tick` after reset release, with `en` held high: the cycle in which the prescaler reads 2^W−1, i.e. cycle 2^W−1, counting the first post-release edge as cycle 0 result. Subsequent ticks follow every 2^W cycles.
- `en` low mid-count: prescaler, `cnt`, and `lvl` freeze. Counting resumes on the same phase when `en` returns high.
- Asynchronous `reset` assertion clears all outputs without waiting for a `clk` edge. Release is sampled on the next rising edge.

## Test plan
Unless stated otherwise, N=4, PRESCALE_W=4, STABLE_CNT=3, `en`=1.

- Reset and tick cadence:
  - Stimulus: hold `reset`=0, then release.
  - Response: all outputs 0 during reset. `tick` high at cycles 15, 31, 47 after release, and low elsewhere.
- Clean press:
  - Stimulus: `btn_in[0]` 0→1 and held.
  - Response: `btn_level[0]`=1 after the 3rd tick following `s2` going high. `btn_rise[0]` is high exactly that one cycle. Other channels stay 0 with no pulses.
- Bounce rejection:
  - Stimulus: `btn_in[1]` high for 2 ticks, low across 1 tick, then high.
  - Response: `cnt` resets at the low tick. `btn_level[1]` rises only after 3 further consecutive high ticks, with a single `btn_rise[1]`.
- Enable freeze:
  - Stimulus: start a press on ch2, drop `en` after 2 ticks for 40 cycles, then restore.
  - Response: no `tick` while `en`=0 and `btn_level[2]` stays 0. It rises on the first tick after restore.
- Simultaneous events:
  - Stimulus: ch2 at level 1 is released while ch3 is pressed, on the same edge.
  - Response: `btn_fall[2]` and `btn_rise[3]` are both high in the same single cycle.
- Asynchronous reset mid-count:
  - Stimulus: press ch0 for 2 ticks, then assert `reset` between clock edges.
  - Response: all outputs 0 immediately. After release, a held ch0 needs a full 3 new ticks before `btn_rise[0]`.
